// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// downstream hold, branch flush and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic              id_ALUSrc,
  input  logic              id_Branch,
  input  logic [1:0]        id_ALUOp,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemtoReg,
  output logic              ex_ALUSrc,
  output logic              ex_Branch,
  output logic [1:0]        ex_ALUOp,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              branch;
    logic [1:0]        alu_op;
  } stage_t;

  stage_t ex_q;
  stage_t id_cap;
  logic   uses_rs1;
  logic   uses_rs2;
  logic   hazard;

  // An invalid slot is captured with its control bits forced low so it can never
  // write the register file or touch memory.
  // NOTE: always_comb assigns a full default first so no path can infer a latch.
  always_comb begin
    id_cap          = '0;
    id_cap.valid    = id_valid;
    id_cap.pc       = id_pc;
    id_cap.rs1_data = id_rs1_data;
    id_cap.rs2_data = id_rs2_data;
    id_cap.imm      = id_imm;
    id_cap.rs1      = id_rs1;
    id_cap.rs2      = id_rs2;
    id_cap.rd       = id_rd;
    id_cap.funct3   = id_funct3;
    id_cap.funct7b5 = id_funct7b5;
    if (id_valid) begin
      id_cap.reg_write  = id_RegWrite;
      id_cap.mem_read   = id_MemRead;
      id_cap.mem_write  = id_MemWrite;
      id_cap.mem_to_reg = id_MemtoReg;
      id_cap.alu_src    = id_ALUSrc;
      id_cap.branch     = id_Branch;
      id_cap.alu_op     = id_ALUOp;
    end
  end

  // rs2 matters for R-type and branches (ALUSrc=0) and for stores (store data).
  assign uses_rs1 = id_valid;
  assign uses_rs2 = id_valid & (~id_ALUSrc | id_MemWrite);
  assign hazard   = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));
  assign stall_o  = (hazard & ~flush) | ex_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (ex_hold) begin
      ex_q       <= ex_q;
      bubble_cnt <= bubble_cnt;
    end else if (hazard) begin
      ex_q <= '0;
      if (bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      ex_q <= id_cap;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_MemtoReg = ex_q.mem_to_reg;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_Branch   = ex_q.branch;
  assign ex_ALUOp    = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed vectors push expected EX state,
// a monitor pops and compares one cycle later; a CNT_W=2 twin covers saturation.
module tb_id_ex_pipe_reg;
  localparam int W = 284;

  typedef struct {
    logic        valid;
    logic [63:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic        regw, memr, memw, m2r, alusrc, branch;
    logic [1:0]  aluop;
  } ins_t;

  typedef struct {
    ins_t        ex;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_funct7b5, ex_hold, flush;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch;
  logic [1:0]  id_ALUOp;

  logic stall_o, ex_valid, ex_funct7b5;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch;
  logic [1:0]  ex_ALUOp;
  logic [15:0] bubble_cnt;

  logic s2_stall, s2_valid, s2_f7;
  logic [63:0] s2_pc, s2_rs1d, s2_rs2d, s2_imm;
  logic [4:0]  s2_rs1, s2_rs2, s2_rd;
  logic [2:0]  s2_f3;
  logic s2_regw, s2_memr, s2_memw, s2_m2r, s2_alusrc, s2_branch;
  logic [1:0]  s2_aluop;
  logic [1:0]  s2_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  exp_t cur;
  int   hand_cnt = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(64), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc),
    .id_Branch(id_Branch), .id_ALUOp(id_ALUOp), .ex_hold(ex_hold), .flush(flush),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
    .ex_ALUOp(ex_ALUOp), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.XLEN(64), .REG_AW(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc),
    .id_Branch(id_Branch), .id_ALUOp(id_ALUOp), .ex_hold(ex_hold), .flush(flush),
    .stall_o(s2_stall), .ex_valid(s2_valid), .ex_pc(s2_pc), .ex_rs1_data(s2_rs1d),
    .ex_rs2_data(s2_rs2d), .ex_imm(s2_imm), .ex_rs1(s2_rs1), .ex_rs2(s2_rs2),
    .ex_rd(s2_rd), .ex_funct3(s2_f3), .ex_funct7b5(s2_f7),
    .ex_RegWrite(s2_regw), .ex_MemRead(s2_memr), .ex_MemWrite(s2_memw),
    .ex_MemtoReg(s2_m2r), .ex_ALUSrc(s2_alusrc), .ex_Branch(s2_branch),
    .ex_ALUOp(s2_aluop), .bubble_cnt(s2_cnt)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input ins_t s);
    return W'({s.valid, s.pc, s.rs1d, s.rs2d, s.imm, s.rs1, s.rs2, s.rd, s.f3, s.f7,
               s.regw, s.memr, s.memw, s.m2r, s.alusrc, s.branch, s.aluop});
  endfunction

  function automatic ins_t mk(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [63:0] d1, input logic [63:0] d2,
                              input logic regw, input logic memr, input logic memw,
                              input logic m2r, input logic alusrc, input logic br,
                              input logic [1:0] aluop);
    ins_t s;
    s.valid = v; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.rs1d = d1; s.rs2d = d2; s.imm = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(rd);
    s.f3 = rd[2:0]; s.f7 = rs1[0];
    s.regw = regw; s.memr = memr; s.memw = memw; s.m2r = m2r;
    s.alusrc = alusrc; s.branch = br; s.aluop = aluop;
    return s;
  endfunction

  function automatic ins_t gate(input ins_t s);
    ins_t r = s;
    if (!s.valid) begin
      r.regw = 0; r.memr = 0; r.memw = 0; r.m2r = 0; r.alusrc = 0; r.branch = 0; r.aluop = 2'b00;
    end
    return r;
  endfunction

  function automatic ins_t zero_ins();
    return mk(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 0, 0, 0, 0, 0, 0, 2'b00)
           ;
  endfunction

  task automatic drive(input ins_t s);
    id_valid = s.valid; id_pc = s.pc; id_rs1_data = s.rs1d; id_rs2_data = s.rs2d;
    id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_funct3 = s.f3;
    id_funct7b5 = s.f7; id_RegWrite = s.regw; id_MemRead = s.memr; id_MemWrite = s.memw;
    id_MemtoReg = s.m2r; id_ALUSrc = s.alusrc; id_Branch = s.branch; id_ALUOp = s.aluop;
  endtask

  // kind: 0 capture, 1 flush bubble, 2 hazard bubble, 3 hold (hand-chosen per vector)
  task automatic step(input string name, input ins_t s, input logic fl, input logic hd,
                      input logic exp_stall, input int kind);
    ins_t zi;
    @(negedge clk);
    drive(s); flush = fl; ex_hold = hd;
    #1;
    check({name, ".stall"}, W'(stall_o), W'(exp_stall));
    zi = zero_ins();
    zi.imm = 64'd0;
    case (kind)
      0: cur.ex = gate(s);
      1: cur.ex = zi;
      2: begin cur.ex = zi; hand_cnt++; end
      default: ;
    endcase
    cur.cnt  = 16'(hand_cnt);
    cur.cnt2 = (hand_cnt > 3) ? 2'd3 : 2'(hand_cnt);
    sb.push_back(cur);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ex_valid", W'(ex_valid), W'(e.ex.valid));
      check("ex_data", W'({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}),
            W'({e.ex.pc, e.ex.rs1d, e.ex.rs2d, e.ex.imm}));
      check("ex_idx", W'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5}),
            W'({e.ex.rs1, e.ex.rs2, e.ex.rd, e.ex.f3, e.ex.f7}));
      check("ex_ctrl", W'({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc,
                           ex_Branch, ex_ALUOp}),
            W'({e.ex.regw, e.ex.memr, e.ex.memw, e.ex.m2r, e.ex.alusrc, e.ex.branch, e.ex.aluop}));
      check("bubble_cnt", W'(bubble_cnt), W'(e.cnt));
      check("sat_twin_state", pack('{s2_valid, s2_pc, s2_rs1d, s2_rs2d, s2_imm, s2_rs1, s2_rs2,
                                     s2_rd, s2_f3, s2_f7, s2_regw, s2_memr, s2_memw, s2_m2r,
                                     s2_alusrc, s2_branch, s2_aluop}), pack(e.ex));
      check("sat_twin_cnt", W'(s2_cnt), W'(e.cnt2));
    end
  end

  task automatic check_cleared(input string name);
    check({name, ".ex_all"}, W'({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1,
                                 ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_RegWrite,
                                 ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc,
                                 ex_Branch, ex_ALUOp}), '0);
    check({name, ".cnt"}, W'({bubble_cnt, s2_cnt, s2_valid}), '0);
    check({name, ".stall"}, W'(stall_o), '0);
  endtask

  initial begin
    ins_t add1, ld7, add7, ldb, addi, ld0, addx0, sd7, beq, add3, inv, nop;
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    cur.ex = zero_ins(); cur.ex.imm = 64'd0; cur.cnt = 0; cur.cnt2 = 0;
    drive(cur.ex);

    // Reset with random ID-side activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      id_valid = 1'b1; id_pc = {$urandom, $urandom}; id_rs1_data = {$urandom, $urandom};
      id_rs2_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
      id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
      {id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch} = 6'($urandom);
      id_ALUOp = 2'($urandom);
      @(posedge clk); #1;
      check_cleared("reset");
    end
    @(negedge clk); rst_n = 1'b1;

    add1  = mk(1, 64'h100, 5'd3, 5'd4, 5'd5, 64'h11, 64'h22, 1, 0, 0, 0, 0, 0, 2'b10);
    ld7   = mk(1, 64'h104, 5'd1, 5'd9, 5'd7, 64'h1000, 64'h0, 1, 1, 0, 1, 1, 0, 2'b00);
    add7  = mk(1, 64'h108, 5'd1, 5'd7, 5'd8, 64'h5, 64'h6, 1, 0, 0, 0, 0, 0, 2'b10);
    ldb   = mk(1, 64'h110, 5'd2, 5'd3, 5'd7, 64'h2000, 64'h0, 1, 1, 0, 1, 1, 0, 2'b00);
    addi  = mk(1, 64'h114, 5'd2, 5'd7, 5'd9, 64'h33, 64'h44, 1, 0, 0, 0, 1, 0, 2'b00);
    ld0   = mk(1, 64'h118, 5'd3, 5'd4, 5'd0, 64'h3000, 64'h0, 1, 1, 0, 1, 1, 0, 2'b00);
    addx0 = mk(1, 64'h11C, 5'd0, 5'd0, 5'd10, 64'h0, 64'h0, 1, 0, 0, 0, 0, 0, 2'b10);
    sd7   = mk(1, 64'h124, 5'd2, 5'd7, 5'd0, 64'h4000, 64'h77, 0, 0, 1, 0, 1, 0, 2'b00);
    beq   = mk(1, 64'h128, 5'd1, 5'd2, 5'd0, 64'h8, 64'h8, 0, 0, 0, 0, 0, 1, 2'b01);
    add3  = mk(1, 64'h12C, 5'd4, 5'd5, 5'd6, 64'hAA, 64'hBB, 1, 0, 0, 0, 0, 0, 2'b10);
    inv   = mk(0, 64'h130, 5'd7, 5'd7, 5'd5, 64'hDEAD, 64'hBEEF, 1, 1, 1, 1, 1, 1, 2'b11);
    nop   = mk(1, 64'h134, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 2'b00);

    step("add",        add1, 0, 0, 0, 0);
    step("ld7",        ld7,  0, 0, 0, 0);
    step("loaduse",    add7, 0, 0, 1, 2);
    step("after_bub",  add7, 0, 0, 0, 0);
    step("ld7b",       ldb,  0, 0, 0, 0);
    step("addi_rs2",   addi, 0, 0, 0, 0);
    step("ld_x0",      ld0,  0, 0, 0, 0);
    step("use_x0",     addx0,0, 0, 0, 0);
    step("ld7c",       ld7,  0, 0, 0, 0);
    step("sd_hazard",  sd7,  0, 0, 1, 2);
    step("sd_cap",     sd7,  0, 0, 0, 0);
    step("flush_beq",  beq,  1, 0, 0, 1);
    step("add3",       add3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold", beq, 0, 1, 1, 3);
    step("beq_cap",    beq,  0, 0, 0, 0);
    step("invalid",    inv,  0, 0, 0, 0);
    step("zero_ctrl",  nop,  0, 0, 0, 0);
    step("flush_hold", add3, 1, 1, 1, 1);
    step("ld7d",       ld7,  0, 0, 0, 0);
    step("flush_haz",  add7, 1, 0, 0, 1);
    step("ld7e",       ld7,  0, 0, 0, 0);
    step("hold_haz",   add7, 0, 1, 1, 3);
    step("haz_after",  add7, 0, 0, 1, 2);
    step("add7_cap",   add7, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("sat_ld",   ld7,  0, 0, 0, 0);
      step("sat_haz",  add7, 0, 0, 1, 2);
    end

    // Asynchronous reset mid-cycle with a nonzero counter and valid EX slot
    step("pre_rst",    add1, 0, 0, 0, 0);
    @(negedge clk); #3; rst_n = 1'b0; #1;
    check_cleared("async_rst");
    @(negedge clk); rst_n = 1'b1;
    hand_cnt = 0;
    step("post_rst",   add1, 0, 0, 0, 0);

    @(negedge clk); @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register sitting directly downstream of control_unit and the register file.
- Latches the decoded control bits (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp), the operand data, the immediate and the register indices into the EX stage.
- Contains load-use hazard detection: on a hazard it inserts a bubble and requests a front-end stall.
- Supports downstream hold and branch flush, and counts inserted bubbles for performance monitoring.

Parameters:
XLEN, 64, data/PC width (RV64: ld/sd)
REG_AW, 5, register index width
CNT_W, 16, bubble counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1_data  input  XLEN  register file read port 1
id_rs2_data  input  XLEN  register file read port 2
id_imm  input  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  input  REG_AW each  register indices
id_funct3  input  3  funct3 field
id_funct7b5  input  1  instr[30]
id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch  input  1 each  control_unit outputs
id_ALUOp  input  2  control_unit ALUOp
ex_hold  input  1  downstream stall: freeze this register
flush  input  1  branch taken in EX: kill ID instruction
stall_o  output  1  hold PC and IF/ID (combinational)
ex_valid  output  1  EX instruction valid
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  output  REG_AW each  registered indices
ex_funct3  output  3  registered funct3
ex_funct7b5  output  1  registered instr[30]
ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch  output  1 each  registered control bits
ex_ALUOp  output  2  registered ALUOp
bubble_cnt  output  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output is 0, ex_valid=0, bubble_cnt=0. stall_o evaluates with ex_MemRead=0, so it is 0 during reset.
- Operand-use decode:
  - uses_rs1 = id_valid.
  - uses_rs2 = id_valid & (~id_ALUSrc | id_MemWrite), covering R-type, beq and sd.
- Load-use hazard (combinational): hazard = ex_valid & ex_MemRead & (ex_rd!=0) & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- stall_o = (hazard & ~flush) | ex_hold.
- Priority at each rising edge, highest first:
  1. flush: load a bubble.
  2. ex_hold: keep all ex_* and bubble_cnt unchanged.
  3. hazard: load a bubble and increment bubble_cnt.
  4. Otherwise capture all id_* into ex_*, with ex_valid=id_valid.
- Bubble: ex_valid=0; ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_ALUSrc=0; ex_ALUOp=00. Data/index fields are don't-care; the implementation zeroes them.
- Capture when id_valid=0: control bits are still forced to 0, so an invalid slot never writes or accesses memory.
- All-zero control: opcode 0000000 yields all-zero control and is captured as valid with no side effects.
- Latency: one cycle from ID to EX. A hazard costs exactly one bubble, because the load advances out of EX the following cycle.
- bubble_cnt saturates at all-ones with no wrap. It increments only on a hazard-bubble edge, not on a flush bubble or during hold.
- Simultaneous events:
  - flush+hazard: the flush bubble wins and bubble_cnt is unchanged.
  - flush+ex_hold: flush wins.
  - hold+hazard: hold wins, and the hazard is re-evaluated on the next cycle.
- Reset deasserted mid-stream: the first edge after release behaves per the priority list, starting from the cleared state.

Test Plan:
- Reset: hold rst_n=0 with random id_* toggling over 3 edges -> all ex_* =0, ex_valid=0, bubble_cnt=0, stall_o=0. Assert rst_n asynchronously mid-cycle -> outputs clear immediately.
- Pass-through add: id_valid=1, RegWrite=1, ALUOp=10, ALUSrc=0, rs1=3, rs2=4, rd=5, rs1_data=0x11, rs2_data=0x22 -> next edge ex_* equal the inputs, ex_valid=1, stall_o=0.
- Load-use: load rd=7 (MemRead=1) in EX, then add with rs2=7 in ID -> stall_o=1 and the next edge gives a bubble (ex_valid=0, all control 0), bubble_cnt=1. The following edge captures the add.
- No false hazard:
  - addi (ALUSrc=1) whose rs2 field=7 behind ld rd=7 -> stall_o=0.
  - ld rd=0 followed by use of x0 -> stall_o=0.
  - sd with rs2=7 behind ld rd=7 -> stall_o=1.
- Flush/hold:
  - flush=1 with a valid beq in ID -> bubble, bubble_cnt unchanged.
  - ex_hold=1 for 3 cycles -> ex_* frozen and stall_o=1.
  - flush+hazard together -> one bubble and no count.
- Saturation: CNT_W=2, force 5 hazard bubbles -> bubble_cnt ends at 3.
